// File: rtl/mem_cmd_pkg.sv
// Shared definitions for the memory command issuer: opcodes, module IDs,
// FSM state encoding, beat counts and header packing.
package mem_cmd_pkg;

   // Command opcodes
   localparam logic [1:0] RD_KEY  = 2'd0;
   localparam logic [1:0] RD_TEXT = 2'd1;
   localparam logic [1:0] WR_RES  = 2'd2;
   localparam logic [1:0] HASH_OP = 2'd3;

   // Module IDs on the command and ack buses
   localparam logic [1:0] MEM  = 2'd0;
   localparam logic [1:0] SHA  = 2'd1;
   localparam logic [1:0] AES  = 2'd2;
   localparam logic [1:0] CTRL = 2'd3;

   localparam int unsigned KEY_BYTES  = 32;
   localparam int unsigned TEXT_BYTES = 16;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StWdata,
      StRdata,
      StWaitAck,
      StRsp
   } state_e;

   // Header byte 0: {enc_dec, reserved 0, dest, source, opcode}
   function automatic logic [7:0] pack_header(input logic       enc_dec,
                                              input logic [1:0] dest,
                                              input logic [1:0] source,
                                              input logic [1:0] opcode);
      return {enc_dec, 1'b0, dest, source, opcode};
   endfunction

   // Data beats following the header; SHA results are a full 32-byte digest
   function automatic logic [5:0] beat_count(input logic [1:0] opcode,
                                             input logic [1:0] source);
      logic [5:0] n;
      case (opcode)
         RD_KEY:  n = 6'(KEY_BYTES);
         RD_TEXT: n = 6'(TEXT_BYTES);
         WR_RES:  n = (source == SHA) ? 6'(KEY_BYTES) : 6'(TEXT_BYTES);
         default: n = 6'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_cmd_issuer_if.sv
// Command request, tx/rx byte buses, ack bus and response of the issuer.
// master: the issuer itself; slave: the controller/bus side facing it.
interface mem_cmd_issuer_if;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_opcode;
   logic [1:0]   cmd_source;
   logic [1:0]   cmd_dest;
   logic         cmd_enc_dec;
   logic [23:0]  cmd_addr;
   logic [255:0] cmd_wdata;

   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;

   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         rx_ready;

   logic         ack_valid;
   logic [1:0]   ack_id;

   logic         rsp_valid;
   logic [255:0] rsp_data;
   logic         rsp_err;
   logic         busy;

   modport master (
      input  cmd_valid, cmd_opcode, cmd_source, cmd_dest, cmd_enc_dec, cmd_addr, cmd_wdata,
      input  tx_ready, rx_data, rx_valid, ack_valid, ack_id,
      output cmd_ready, tx_data, tx_valid, rx_ready, rsp_valid, rsp_data, rsp_err, busy
   );

   modport slave (
      output cmd_valid, cmd_opcode, cmd_source, cmd_dest, cmd_enc_dec, cmd_addr, cmd_wdata,
      output tx_ready, rx_data, rx_valid, ack_valid, ack_id,
      input  cmd_ready, tx_data, tx_valid, rx_ready, rsp_valid, rsp_data, rsp_err, busy
   );
endinterface

// File: rtl/cmd_tx_serializer.sv
// Byte-wide valid/ready output stage: a load strobe presents a byte, which is
// held stable until the receiver accepts it; done_o flags the accepting cycle.
module cmd_tx_serializer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] byte_i,
   input  logic       tx_ready_i,
   output logic       tx_valid_o,
   output logic [7:0] tx_data_o,
   output logic       done_o
);

   logic       valid_q, valid_d;
   logic [7:0] data_q, data_d;

   assign done_o     = valid_q && tx_ready_i;
   assign tx_valid_o = valid_q;
   assign tx_data_o  = data_q;

   // A load on the transfer cycle keeps valid high for back-to-back beats
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = byte_i;
      end else if (done_o) begin
         valid_d = 1'b0;
      end
   end

   // Output register; reset drops tx_valid immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/mem_cmd_issuer.sv
// Memory command issuer: captures a command, sends header + address bytes,
// then streams write data or collects read data, and waits for the ack.
// Optional build macro MEM_CMD_ACK_TIMEOUT_EN bounds the ack wait.
module mem_cmd_issuer
   import mem_cmd_pkg::*;
#(
   parameter logic [1:0]  MY_ID       = CTRL,
   parameter int unsigned ACK_TIMEOUT = 1023
) (
   input logic              clk,
   input logic              rst_n,
   mem_cmd_issuer_if.master bus_io
);

   state_e       state_q, state_d;
   logic [5:0]   cnt_q, cnt_d;
   logic [5:0]   n_q, n_d;
   logic [1:0]   op_q, op_d;
   logic [23:0]  addr_q, addr_d;
   logic [255:0] wsh_q, wsh_d;
   logic [255:0] rsp_data_q, rsp_data_d;
   logic         ack_seen_q, ack_seen_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic         rx_ready_q, rx_ready_d;
   logic         cmd_ready_q, cmd_ready_d;
   logic         busy_q, busy_d;

   logic         ld;
   logic [7:0]   ld_byte;
   logic         tx_done;
   logic         tx_valid;
   logic [7:0]   tx_data;
   logic         ack_hit;

`ifdef MEM_CMD_ACK_TIMEOUT_EN
   localparam int unsigned    ToW    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ToW-1:0] ToLast = ToW'(ACK_TIMEOUT - 1);
   logic [ToW-1:0] to_cnt_q, to_cnt_d;
   logic           rsp_err_q, rsp_err_d;
`endif

   cmd_tx_serializer u_tx (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ld),
      .byte_i     (ld_byte),
      .tx_ready_i (bus_io.tx_ready),
      .tx_valid_o (tx_valid),
      .tx_data_o  (tx_data),
      .done_o     (tx_done)
   );

   // Next-state, capture, byte sequencing and ack tracking
   always_comb begin
      ack_hit    = bus_io.ack_valid && (bus_io.ack_id == MY_ID);
      state_d    = state_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wsh_d      = wsh_q;
      rsp_data_d = rsp_data_q;
      ack_seen_d = ack_seen_q;
      ld         = 1'b0;
      ld_byte    = 8'h00;
`ifdef MEM_CMD_ACK_TIMEOUT_EN
      to_cnt_d   = '0;
      rsp_err_d  = rsp_err_q;
`endif
      case (state_q)
         StIdle: begin
            if (bus_io.cmd_valid) begin
               op_d       = bus_io.cmd_opcode;
               n_d        = beat_count(bus_io.cmd_opcode, bus_io.cmd_source);
               addr_d     = bus_io.cmd_addr;
               // Left-align 16-byte payloads so both sizes drain from the top byte
               wsh_d      = (n_d == 6'(KEY_BYTES)) ? bus_io.cmd_wdata
                                                   : {bus_io.cmd_wdata[127:0], 128'h0};
               rsp_data_d = '0;
               cnt_d      = '0;
               ld         = 1'b1;
               ld_byte    = pack_header(bus_io.cmd_enc_dec, bus_io.cmd_dest,
                                        bus_io.cmd_source, bus_io.cmd_opcode);
               state_d    = StHdr;
`ifdef MEM_CMD_ACK_TIMEOUT_EN
               rsp_err_d  = 1'b0;
`endif
            end
         end
         StHdr: begin
            if (ack_hit) ack_seen_d = 1'b1;
            if (tx_done) begin
               if (cnt_q == 6'd3) begin
                  cnt_d = '0;
                  if (op_q == WR_RES) begin
                     state_d = StWdata;
                     ld      = 1'b1;
                     ld_byte = wsh_q[255:248];
                     wsh_d   = {wsh_q[247:0], 8'h00};
                  end else if (op_q == HASH_OP) begin
                     state_d = StWaitAck;
                  end else begin
                     state_d = StRdata;
                  end
               end else begin
                  cnt_d   = cnt_q + 6'd1;
                  ld      = 1'b1;
                  ld_byte = addr_q[7:0];
                  addr_d  = {8'h00, addr_q[23:8]};
               end
            end
         end
         StWdata: begin
            if (ack_hit) ack_seen_d = 1'b1;
            if (tx_done) begin
               if (cnt_q == n_q - 6'd1) begin
                  cnt_d   = '0;
                  state_d = StWaitAck;
               end else begin
                  cnt_d   = cnt_q + 6'd1;
                  ld      = 1'b1;
                  ld_byte = wsh_q[255:248];
                  wsh_d   = {wsh_q[247:0], 8'h00};
               end
            end
         end
         StRdata: begin
            if (ack_hit) ack_seen_d = 1'b1;
            if (bus_io.rx_valid) begin
               rsp_data_d = {rsp_data_q[247:0], bus_io.rx_data};
               if (cnt_q == n_q - 6'd1) begin
                  cnt_d   = '0;
                  state_d = StWaitAck;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         StWaitAck: begin
            if (ack_seen_q || ack_hit) begin
               state_d = StRsp;
`ifdef MEM_CMD_ACK_TIMEOUT_EN
            end else if (to_cnt_q == ToLast) begin
               state_d   = StRsp;
               rsp_err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + ToW'(1);
`endif
            end
         end
         StRsp: begin
            state_d    = StIdle;
            ack_seen_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase

      rsp_valid_d = (state_d == StRsp);
      rx_ready_d  = (state_d == StRdata);
      cmd_ready_d = (state_d == StIdle);
      busy_d      = (state_d != StIdle);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         n_q         <= '0;
         op_q        <= '0;
         addr_q      <= '0;
         wsh_q       <= '0;
         rsp_data_q  <= '0;
         ack_seen_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rx_ready_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wsh_q       <= wsh_d;
         rsp_data_q  <= rsp_data_d;
         ack_seen_q  <= ack_seen_d;
         rsp_valid_q <= rsp_valid_d;
         rx_ready_q  <= rx_ready_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

`ifdef MEM_CMD_ACK_TIMEOUT_EN
   // Ack-wait timeout counter and error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q  <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign bus_io.rsp_err = rsp_err_q;
`else
   assign bus_io.rsp_err = 1'b0;
`endif

   assign bus_io.tx_valid  = tx_valid;
   assign bus_io.tx_data   = tx_data;
   assign bus_io.rx_ready  = rx_ready_q;
   assign bus_io.rsp_valid = rsp_valid_q;
   assign bus_io.rsp_data  = rsp_data_q;
   assign bus_io.cmd_ready = cmd_ready_q;
   assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_mem_cmd_issuer.sv
// Bench for mem_cmd_issuer: a table of commands is run through the DUT while
// scoreboards hold the expected tx bytes and responses.
module tb_mem_cmd_issuer;
   import mem_cmd_pkg::*;

   localparam logic [1:0]  MyId  = 2'b11;
   localparam int unsigned AckTo = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_cmd_issuer_if bus ();

   mem_cmd_issuer #(
      .MY_ID       (MyId),
      .ACK_TIMEOUT (AckTo)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   // ack_mode: 0 early (during header), 1 late, 2 late after a foreign ack, 3 no ack
   typedef struct {
      logic [1:0]   op;
      logic [1:0]   src;
      logic [1:0]   dst;
      logic         enc;
      logic [23:0]  addr;
      logic [255:0] wdata;
      logic [7:0]   rx_base;
      int           rdy_mode;
      bit           rx_gaps;
      int           ack_mode;
      int           exp_lat;
   } vec_t;

   typedef struct packed {
      logic [255:0] data;
      logic         err;
   } rsp_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   int         rsp_cyc = 0;
   int         rdy_mode = 0;
   bit         rx_gaps  = 1'b0;
   bit         tog      = 1'b0;
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   rsp_t       rspq[$];
   vec_t       vecs[7];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   function automatic int model_beats(input logic [1:0] op, input logic [1:0] src);
      if (op == RD_KEY) return 32;
      if (op == RD_TEXT) return 16;
      if (op == WR_RES) return (src == SHA) ? 32 : 16;
      return 0;
   endfunction

   // tx_ready pattern: 0 always ready, 1 toggling, 2 random
   always @(posedge clk) begin
      #1;
      tog = ~tog;
      case (rdy_mode)
         0:       bus.tx_ready = 1'b1;
         1:       bus.tx_ready = tog;
         default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Read-data source: offers queued bytes, pops one per accepted beat
   always begin
      bit xfer;
      @(negedge clk);
      xfer = bus.rx_valid && bus.rx_ready;
      @(posedge clk);
      #1;
      if (xfer && rxq.size() > 0) void'(rxq.pop_front());
      if (rst_n && rxq.size() > 0 && (!rx_gaps || $urandom_range(0, 2) != 0)) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = rxq[0];
      end else begin
         bus.rx_valid = 1'b0;
         bus.rx_data  = 8'($urandom);
      end
   end

   // Monitor: tx byte scoreboard, stall stability, response scoreboard
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("tx_valid held while stalled", 256'(bus.tx_valid), 256'd1);
            check("tx_data stable while stalled", 256'(bus.tx_data), 256'(prev_data));
         end
         if (bus.tx_valid && bus.tx_ready) begin
            if (txq.size() == 0) flag($sformatf("unexpected tx beat 0x%0h", bus.tx_data));
            else check("tx byte", 256'(bus.tx_data), 256'(txq.pop_front()));
         end
         prev_stall = bus.tx_valid && !bus.tx_ready;
         prev_data  = bus.tx_data;
         if (bus.rsp_valid) begin
            rsp_t r;
            rsp_cyc = cyc;
            if (rspq.size() == 0) begin
               flag("unexpected rsp_valid");
            end else begin
               r = rspq.pop_front();
               check("rsp_data", bus.rsp_data, r.data);
               check("rsp_err", 256'(bus.rsp_err), 256'(r.err));
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, " tx_valid"}, 256'(bus.tx_valid), 256'd0);
      check({tag, " tx_data"}, 256'(bus.tx_data), 256'd0);
      check({tag, " rx_ready"}, 256'(bus.rx_ready), 256'd0);
      check({tag, " rsp_valid"}, 256'(bus.rsp_valid), 256'd0);
      check({tag, " rsp_data"}, bus.rsp_data, 256'd0);
      check({tag, " rsp_err"}, 256'(bus.rsp_err), 256'd0);
      check({tag, " cmd_ready"}, 256'(bus.cmd_ready), 256'd1);
      check({tag, " busy"}, 256'(bus.busy), 256'd0);
   endtask

   task automatic pulse_ack(input logic [1:0] id);
      bus.ack_valid = 1'b1;
      bus.ack_id    = id;
      @(posedge clk);
      #1;
      bus.ack_valid = 1'b0;
   endtask

   task automatic wait_data(input int limit);
      int k;
      for (k = 0; k < limit; k++) begin
         if (txq.size() == 0 && rxq.size() == 0) break;
         @(posedge clk);
         #1;
      end
      if (k == limit) begin
         flag($sformatf("data phase timeout, %0d tx / %0d rx left", txq.size(), rxq.size()));
         txq.delete();
         rxq.delete();
      end
   endtask

   task automatic wait_rsp(input int limit);
      int k;
      for (k = 0; k < limit; k++) begin
         if (rspq.size() == 0) break;
         @(posedge clk);
         #1;
      end
      if (k == limit) begin
         flag("rsp_valid never arrived");
         rspq.delete();
      end
   endtask

   // Load scoreboards for a command and present it for one cycle
   task automatic issue(input vec_t v, output int cap, output rsp_t r);
      int         n;
      logic [7:0] b;
      n = model_beats(v.op, v.src);
      rdy_mode = v.rdy_mode;
      rx_gaps  = v.rx_gaps;
      r.data = '0;
      r.err  = 1'b0;
      txq.push_back({v.enc, 1'b0, v.dst, v.src, v.op});
      txq.push_back(v.addr[7:0]);
      txq.push_back(v.addr[15:8]);
      txq.push_back(v.addr[23:16]);
      if (v.op == WR_RES)
         for (int i = 0; i < n; i++) txq.push_back(v.wdata[(n-1-i)*8 +: 8]);
      if (v.op == RD_KEY || v.op == RD_TEXT)
         for (int i = 0; i < n; i++) begin
            b = v.rx_base + 8'(i);
            rxq.push_back(b);
            r.data[(n-1-i)*8 +: 8] = b;
         end
      check("cmd_ready before command", 256'(bus.cmd_ready), 256'd1);
      check("busy before command", 256'(bus.busy), 256'd0);
      bus.cmd_opcode  = v.op;
      bus.cmd_source  = v.src;
      bus.cmd_dest    = v.dst;
      bus.cmd_enc_dec = v.enc;
      bus.cmd_addr    = v.addr;
      bus.cmd_wdata   = v.wdata;
      bus.cmd_valid   = 1'b1;
      @(posedge clk);
      #1;
      cap = cyc;
      // Scramble fields after capture; the DUT must not look at them again
      bus.cmd_valid   = 1'b0;
      bus.cmd_opcode  = 2'($urandom);
      bus.cmd_source  = 2'($urandom);
      bus.cmd_addr    = 24'($urandom);
      bus.cmd_wdata   = {8{$urandom}};
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   cap;
      int   idle_seen;
      rsp_t r;
      issue(v, cap, r);
      if (v.ack_mode == 0) begin
         rspq.push_back(r);
         pulse_ack(MyId);
      end
      wait_data(600);
      if (v.ack_mode == 1 || v.ack_mode == 2) begin
         if (v.ack_mode == 2) pulse_ack(2'b01);
         repeat (4) @(posedge clk);
         #1;
         check({tag, " busy while awaiting ack"}, 256'(bus.busy), 256'd1);
         rspq.push_back(r);
         pulse_ack(MyId);
      end else if (v.ack_mode == 3) begin
`ifdef MEM_CMD_ACK_TIMEOUT_EN
         r.err = 1'b1;
         rspq.push_back(r);
`else
         idle_seen = 0;
         repeat (1000) begin
            @(posedge clk);
            #1;
            if (!bus.busy) idle_seen++;
         end
         check({tag, " idle cycles with no ack"}, 256'(idle_seen), 256'd0);
         rspq.push_back(r);
         pulse_ack(MyId);
`endif
      end
      wait_rsp(200);
      if (v.exp_lat != 0)
         check({tag, " rsp latency"}, 256'(rsp_cyc - cap + 1), 256'(v.exp_lat));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cmd_valid   = 1'b0;
      bus.cmd_opcode  = 2'd0;
      bus.cmd_source  = 2'd0;
      bus.cmd_dest    = 2'd0;
      bus.cmd_enc_dec = 1'b0;
      bus.cmd_addr    = '0;
      bus.cmd_wdata   = '0;
      bus.ack_valid   = 1'b0;
      bus.ack_id      = 2'd0;

      //           op       src   dst   enc   addr         wdata  rx_base rdy gaps ack lat
      vecs[0] = '{HASH_OP, SHA,  AES,  1'b1, 24'h123456, 256'h0, 8'h00, 0, 1'b0, 0, 6};
      vecs[1] = '{WR_RES,  AES,  MEM,  1'b0, 24'hABCDEF,
                  {128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678,
                   128'h00112233_44556677_8899AABB_CCDDEEFF}, 8'h00, 1, 1'b0, 1, 0};
      vecs[2] = '{RD_KEY,  CTRL, MEM,  1'b0, 24'h000040, 256'h0, 8'h01, 2, 1'b1, 2, 0};
      vecs[3] = '{RD_TEXT, CTRL, SHA,  1'b1, 24'hFEDCBA, 256'h0, 8'hF0, 0, 1'b0, 1, 0};
      vecs[4] = '{WR_RES,  SHA,  MEM,  1'b0, 24'h0A0B0C,
                  256'h202122232425262728292A2B2C2D2E2F303132333435363738393A3B3C3D3E3F,
                  8'h00, 2, 1'b0, 0, 0};
      vecs[5] = '{HASH_OP, MEM,  SHA,  1'b0, 24'h000001, 256'h0, 8'h00, 0, 1'b0, 0, 6};
`ifdef MEM_CMD_ACK_TIMEOUT_EN
      vecs[6] = '{HASH_OP, CTRL, MEM,  1'b0, 24'h00BEEF, 256'h0, 8'h00, 0, 1'b0, 3,
                  4 + int'(AckTo) + 1};
`else
      vecs[6] = '{HASH_OP, CTRL, MEM,  1'b0, 24'h00BEEF, 256'h0, 8'h00, 0, 1'b0, 3, 0};
`endif

      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset while data beat 7 of a 16-byte write is on the bus
      begin
         vec_t v;
         int   cap;
         rsp_t r;
         int   k;
         v = vecs[1];
         v.rdy_mode = 0;
         issue(v, cap, r);
         for (k = 0; k < 50; k++) begin
            if (txq.size() <= 9) break;
            @(posedge clk);
            #1;
         end
         check("beats sent before mid reset", 256'(txq.size()), 256'd9);
         rst_n = 1'b0;
         #1;
         check_reset("mid-transfer reset");
         txq.delete();
         rxq.delete();
         rspq.delete();
         repeat (3) @(posedge clk);
         #1;
         check("rsp_valid held in reset", 256'(bus.rsp_valid), 256'd0);
         rst_n = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         check_reset("after reset release");
      end

      run_vec(vecs[5], "post-reset hash");
      run_vec(vecs[6], "no-ack");

      repeat (3) @(posedge clk);
      #1;
      check("busy after final command", 256'(bus.busy), 256'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_cmd_issuer.md
# mem_cmd_issuer

Controller-side initiator for the memory command protocol. Accepts one command per request, serializes it onto the 8-bit command bus as a header byte plus three address bytes, then either streams write data out or collects read data back, and finally waits for the completion ack on the ack bus. It sits between the top-level controller and the shared command bus. It is the transmitting end of the command-port protocol.

## Interface
Parameters:
- MY_ID, 2'b11, ack-bus ID this block answers to (CTRL)
- ACK_TIMEOUT, 1023, cycles allowed in WAIT_ACK (used only with the timeout feature)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset: asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_opcode  in  2  0 RD_KEY, 1 RD_TEXT, 2 WR_RES, 3 HASH_OP
- cmd_source, cmd_dest  in  2 each  module IDs: MEM 0, SHA 1, AES 2, CTRL 3
- cmd_enc_dec  in  1  header bit 7
- cmd_addr  in  24  address
- cmd_wdata  in  256  WR_RES payload
- tx_data  out  8, tx_valid  out  1, tx_ready  in  1  bus toward command port
- rx_data  in  8, rx_valid  in  1, rx_ready  out  1  return bus (read data)
- ack_valid  in  1, ack_id  in  2  ack bus
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  256  read result
- rsp_err  out  1  qualified by rsp_valid
- busy  out  1  state != IDLE

## Operation
- On cmd_valid && cmd_ready, all cmd_* fields are captured. Inputs are ignored afterwards.
- Beat count N is fixed at capture:
  - RD_KEY: 32
  - RD_TEXT: 16
  - WR_RES: 32 if source is SHA, otherwise 16
  - HASH_OP: 0
- States:
  - IDLE: leaves on capture, to HDR.
  - HDR: sends 4 beats.
    - Beat 0 = {enc_dec, 1'b0, dest, source, opcode}.
    - Beats 1..3 = addr[7:0], addr[15:8], addr[23:16].
    - After beat 3: WR_RES goes to WDATA, RD_* goes to RDATA, HASH_OP goes to WAIT_ACK.
  - WDATA: sends N bytes, MSB first.
    - N=32 uses wdata[255:248] first.
    - N=16 uses wdata[127:120] first and ignores wdata[255:128].
    - After the last beat: WAIT_ACK.
  - RDATA: rx_ready=1. Each rx_valid beat shifts in as rsp_data = {rsp_data[247:0], rx_data}; the first byte ends up most significant.
    - rsp_data is cleared at capture, so a 16-byte read leaves [255:128] = 0.
    - After N beats: WAIT_ACK.
  - WAIT_ACK: completes when an ack with ack_id == MY_ID is seen, then goes to RSP.
  - RSP: rsp_valid=1 for one cycle, then IDLE.
- A matching ack arriving in HDR, WDATA or RDATA is latched in ack_seen. WAIT_ACK then exits on its first cycle.
- ack_seen clears on entry to IDLE.
- Acks with ack_id != MY_ID are ignored.
- rx_valid is ignored outside RDATA (rx_ready=0).

## Timing
- Reset values: tx_data=0, tx_valid=0, rx_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=1, busy=0, state IDLE, counters 0.
- All outputs are registered.
- A beat transfers on a cycle with tx_valid && tx_ready.
  - Once raised, tx_valid holds, and tx_data stays stable, until the beat transfers.
  - The next beat is presented the cycle after the transfer (back-to-back at full rate).
- tx_valid rises the cycle after capture.
- Minimum latency, HASH_OP with tx_ready tied 1 and ack present: 4 tx cycles + 1 WAIT_ACK cycle + 1 RSP cycle, so rsp_valid is high 6 cycles after the capture edge.
- Beat counter is 6 bits and compares against N-1. There is no wrap: the counter resets on each state entry.
- Reset asserted mid-transaction:
  - Abandons the transfer immediately; tx_valid drops asynchronously.
  - No rsp_valid is produced.
- Simultaneous final beat and matching ack in the same cycle: the ack is latched, so WAIT_ACK is one cycle.

## Configuration
- MEM_CMD_ACK_TIMEOUT_EN defined:
  - A counter runs in WAIT_ACK.
  - Reaching ACK_TIMEOUT cycles goes to RSP with rsp_err=1.
  - The counter is 10 bits for the default; width is set from ACK_TIMEOUT.
- MEM_CMD_ACK_TIMEOUT_EN undefined:
  - WAIT_ACK waits indefinitely.
  - rsp_err is tied 0.

## Structure
- Shared package mem_cmd_pkg holds:
  - opcode localparams RD_KEY/RD_TEXT/WR_RES/HASH_OP
  - module IDs MEM/SHA/AES/CTRL
  - state encoding
  - beat counts KEY_BYTES=32 and TEXT_BYTES=16
  - the header-packing function
- One natural sub-module: cmd_tx_serializer.
  - Holds the tx_valid/tx_data register and the ready handshake.
  - Takes a byte plus a load strobe; returns a done pulse.

## Test plan
- HASH_OP, addr 0x123456, src SHA, dest AES, enc_dec 1, tx_ready=1, ack id 3 arrives early:
  - tx bytes 0xA7, 0x56, 0x34, 0x12.
  - rsp_valid 6 cycles after capture, rsp_err=0.
- WR_RES src AES, wdata[127:0]=0x00112233…EEFF, tx_ready toggling every cycle:
  - 16 data bytes 0x00..0xFF in order, tx_data stable while stalled.
  - WAIT_ACK until ack id 3.
- RD_KEY, rx bytes 0x01..0x20 with random rx_valid gaps:
  - rsp_data = 0x0102…20.
  - rsp_valid after matching ack; non-matching ack id 1 ignored.
- RD_TEXT, bytes 0xF0..0xFF:
  - rsp_data[127:0] = 0xF0F1…FF, [255:128] = 0.
- rst_n pulsed mid-WDATA (beat 7):
  - all outputs return to reset values, no rsp_valid.
  - A following HASH_OP completes normally.
- With MEM_CMD_ACK_TIMEOUT_EN and ACK_TIMEOUT=20, no ack:
  - rsp_valid with rsp_err=1 after 20 WAIT_ACK cycles.
  - Without the macro, busy stays 1 for 1000 cycles.
